// File: rtl/multiword_addsub_seq.sv
// Wide two's-complement add/subtract built from one N-bit slice, one word per
// clock from the least significant word up, with the carry held in a register between words.
module multiword_addsub_seq #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 op,
  input  logic [N*WORDS-1:0]   a,
  input  logic [N*WORDS-1:0]   b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [N*WORDS-1:0]   result,
  output logic                 cout,
  output logic                 overflow
);

  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg, state_next;
  logic [IW-1:0]  idx_reg, idx_next;
  logic           carry_reg, carry_next;
  logic           op_reg, op_next;
  logic [W-1:0]   a_reg, a_next;
  logic [W-1:0]   b_reg, b_next;
  logic [W-1:0]   work_reg, work_next;
  logic [W-1:0]   result_reg, result_next;
  logic           cout_reg, cout_next;
  logic           overflow_reg, overflow_next;

  logic [N-1:0]   a_words [WORDS];
  logic [N-1:0]   b_words [WORDS];
  logic [N-1:0]   a_word;
  logic [N-1:0]   b_word;
  logic [N:0]     slice_sum;
  logic [W-1:0]   work_merged;
  logic           last_word;

  // work_merged is the working register with the current slice output
  // dropped into word idx, so the final word can go straight to result.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
    assign a_words[gi] = a_reg[gi*N +: N];
    assign b_words[gi] = b_reg[gi*N +: N];
    assign work_merged[gi*N +: N] = (idx_reg == IW'(gi)) ? slice_sum[N-1:0]
                                                         : work_reg[gi*N +: N];
  end

  assign a_word    = a_words[idx_reg];
  assign b_word    = b_words[idx_reg] ^ {N{op_reg}};
  assign slice_sum = {1'b0, a_word} + {1'b0, b_word} + {{N{1'b0}}, carry_reg};
  assign last_word = (idx_reg == IW'(WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      carry_reg    <= 1'b0;
      op_reg       <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      work_reg     <= '0;
      result_reg   <= '0;
      cout_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      carry_reg    <= carry_next;
      op_reg       <= op_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      work_reg     <= work_next;
      result_reg   <= result_next;
      cout_reg     <= cout_next;
      overflow_reg <= overflow_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    carry_next    = carry_reg;
    op_next       = op_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    work_next     = work_reg;
    result_next   = result_reg;
    cout_next     = cout_reg;
    overflow_next = overflow_reg;

    case (state_reg)
      IDLE, DONE: begin
        // Subtract is a + ~b + 1: the +1 enters as the initial carry.
        if (start) begin
          a_next     = a;
          b_next     = b;
          op_next    = op;
          carry_next = op;
          idx_next   = '0;
          state_next = RUN;
        end else if (state_reg == DONE) begin
          state_next = IDLE;
        end
      end
      RUN: begin
        work_next  = work_merged;
        carry_next = slice_sum[N];
        idx_next   = idx_reg + IW'(1);
        if (last_word) begin
          idx_next      = '0;
          state_next    = DONE;
          result_next   = work_merged;
          cout_next     = slice_sum[N];
          overflow_next = (a_reg[W-1] == (b_reg[W-1] ^ op_reg)) &&
                          (slice_sum[N-1] != a_reg[W-1]);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ready    = (state_reg != RUN);
  assign busy     = (state_reg == RUN);
  assign done     = (state_reg == DONE);
  assign result   = result_reg;
  assign cout     = cout_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_multiword_addsub_seq.sv
// Randomised and directed checks of multiword_addsub_seq against a
// full-width arithmetic reference model.
module tb_multiword_addsub_seq;

  localparam int N     = 8;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] last_res;

  multiword_addsub_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain full-width arithmetic; overflow from the exact signed result.
  task automatic model(input logic op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                       output logic [W-1:0] r, output logic c, output logic v);
    logic [W:0] full;
    longint sa, sb, sr, smax, smin;
    if (op_i) full = {1'b0, a_i} + {1'b0, ~b_i} + (W+1)'(1);
    else      full = {1'b0, a_i} + {1'b0, b_i};
    r    = full[W-1:0];
    c    = full[W];
    sa   = longint'($signed(a_i));
    sb   = longint'($signed(b_i));
    sr   = op_i ? (sa - sb) : (sa + sb);
    smax = (longint'(1) <<< (W-1)) - 1;
    smin = -(longint'(1) <<< (W-1));
    v    = (sr > smax) || (sr < smin);
  endtask

  // Called #1 after a clock edge with the DUT ready; returns #1 after the
  // edge that raises done.
  task automatic do_op(input logic op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                       input bit pulse_mid);
    logic [W-1:0] er;
    logic ec, ev;
    int cnt, busy_cnt;
    model(op_i, a_i, b_i, er, ec, ev);
    check("ready_at_start", ready, 1);
    start = 1'b1; op = op_i; a = a_i; b = b_i;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 1'($urandom_range(0, 1));
    cnt = 0; busy_cnt = 0;
    while (!done && cnt < 20) begin
      if (busy) busy_cnt++;
      check("hold_result", result, last_res);
      start = (pulse_mid && cnt == 1);
      @(posedge clk); #1;
      cnt++;
    end
    start = 1'b0;
    check("latency", cnt, WORDS);
    check("busy_cycles", busy_cnt, WORDS);
    check("result", result, er);
    check("cout", cout, ec);
    check("overflow", overflow, ev);
    check("ready_in_done", ready, 1);
    last_res = er;
    $display("op=%0d a=%h b=%h result=%h cout=%0d ovf=%0d exp=%h/%0d/%0d lat=%0d",
             op_i, a_i, b_i, result, cout, overflow, er, ec, ev, cnt);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_ready", ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    last_res = '0;
    #7;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", overflow, 0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(1'b0, 32'h000000FF, 32'h00000001, 0); idle_cycle();
    do_op(1'b1, 32'h00000000, 32'h00000001, 0); idle_cycle();
    do_op(1'b0, 32'h7FFFFFFF, 32'h00000001, 0); idle_cycle();
    do_op(1'b0, 32'hFFFFFFFF, 32'h00000001, 0); idle_cycle();
    do_op(1'b1, 32'h80000000, 32'h00000001, 0); idle_cycle();

    // Back-to-back: second start issued in the DONE cycle.
    do_op(1'b0, 32'h00000001, 32'h00000002, 0);
    do_op(1'b1, 32'h0000000A, 32'h00000003, 0); idle_cycle();

    // Start pulsed during RUN must not launch a second operation.
    do_op(1'b0, 32'h00000005, 32'h00000006, 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("no_extra_done", done, 0);
    end

    // Reset in the second RUN cycle.
    start = 1'b1; op = 1'b0; a = 32'hDEADBEEF; b = 32'h01020304;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_cout", cout, 0);
    check("mid_rst_ovf", overflow, 0);
    #2 rst_n = 1'b1;
    last_res = '0;
    @(posedge clk); #1;
    do_op(1'b0, 32'h12345678, 32'h11111111, 0); idle_cycle();

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom; rb = $urandom;
      if (i % 5 == 0) ra = {1'b1, 31'($urandom)};
      do_op(1'($urandom_range(0, 1)), ra, rb, bit'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
        check("rand_idle_done", done, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
